reg_write_queue: RTL

Write-side initiator for the 8-bit-address / 16-bit-data register block. Accepts register write requests from two producers through valid/ready handshakes, such as the ALU writeback and the load unit. Arbitrates between them round-robin and buffers accepted writes in a small FIFO. Drains one write per cycle onto the register block's Addr_In/Data_In/WE write port.

---
 rtl/reg_write_queue_if.sv | 34 +++
 rtl/reg_write_queue.sv | 110 +++++++++++
 2 files changed

// File: rtl/reg_write_queue_if.sv
// Request/write-port bundle between the two write producers, the queue and the register block.
interface reg_write_queue_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              Req0_Valid;
  logic [ADDR_W-1:0] Req0_Addr;
  logic [DATA_W-1:0] Req0_Data;
  logic              Req0_Ready;
  logic              Req1_Valid;
  logic [ADDR_W-1:0] Req1_Addr;
  logic [DATA_W-1:0] Req1_Data;
  logic              Req1_Ready;
  logic              Hold;
  logic [ADDR_W-1:0] Addr_In;
  logic [DATA_W-1:0] Data_In;
  logic              WE;
  logic [CNT_W-1:0]  Count;
  logic              Full;
  logic              Empty;

  modport master (
    output Req0_Valid, Req0_Addr, Req0_Data, Req1_Valid, Req1_Addr, Req1_Data, Hold,
    input  Req0_Ready, Req1_Ready, Addr_In, Data_In, WE, Count, Full, Empty
  );

  modport slave (
    input  Req0_Valid, Req0_Addr, Req0_Data, Req1_Valid, Req1_Addr, Req1_Data, Hold,
    output Req0_Ready, Req1_Ready, Addr_In, Data_In, WE, Count, Full, Empty
  );
endinterface

// File: rtl/reg_write_queue.sv
// Two-source round-robin register write queue draining one write per cycle onto
// the register block's Addr_In/Data_In/WE port.
module reg_write_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  reg_write_queue_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_prio;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_push;
  logic              w_pop;
  logic              w_contend;
  logic [ENT_W-1:0]  w_entry;
  logic [CNT_W-1:0]  w_count_nxt;

  // Grant uses only registered Full, so a same-cycle pop never opens a slot
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_full) begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end else if (bus.Req0_Valid && bus.Req1_Valid) begin
      w_grant0 = ~r_prio;
      w_grant1 = r_prio;
    end else begin
      w_grant0 = bus.Req0_Valid;
      w_grant1 = bus.Req1_Valid;
    end
  end

  assign w_push    = w_grant0 | w_grant1;
  assign w_pop     = ~r_empty & ~bus.Hold;
  assign w_contend = bus.Req0_Valid & bus.Req1_Valid & w_push;
  assign w_entry   = w_grant1 ? {bus.Req1_Addr, bus.Req1_Data} : {bus.Req0_Addr, bus.Req0_Data};

  // Occupancy after this edge's push/pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage, pointers, priority and the registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {ENT_W{1'b0}};
      end
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_prio  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
      r_data  <= {DATA_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        {r_addr, r_data} <= r_mem[r_rptr];
        r_rptr           <= r_rptr + PTR_W'(1);
        r_we             <= 1'b1;
      end else begin
        r_we <= 1'b0;
      end
      if (w_contend) begin
        r_prio <= ~r_prio;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == {CNT_W{1'b0}});
    end
  end

  assign bus.Req0_Ready = w_grant0;
  assign bus.Req1_Ready = w_grant1;
  assign bus.Addr_In    = r_addr;
  assign bus.Data_In    = r_data;
  assign bus.WE         = r_we;
  assign bus.Count      = r_count;
  assign bus.Full       = r_full;
  assign bus.Empty      = r_empty;
endmodule
